// File: rtl/cache_bus_axi_bridge.sv
// cache_bus_axi_bridge: turns one cache_bus request/response port into an AXI4 master.
// One transaction in flight; uncached single beats and cached INCR bursts.
package cache_bus_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic        burst;
        logic        cached;
        logic [31:0] addr;
        logic [31:0] w_data;
        logic [3:0]  data_strobe;
        logic        data_ok;
        logic        data_last;
    } cache_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic        data_ok;
        logic        data_last;
        logic [31:0] r_data;
    } cache_bus_resp_t;
endpackage

module cache_bus_axi_bridge
    import cache_bus_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  cache_bus_req_t  bus_req_i,
    output cache_bus_resp_t bus_resp_o,
    output logic [3:0]      arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [3:0]      arcache,
    output logic            arvalid,
    input  logic            arready,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [3:0]      awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [3:0]      awcache,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready,
    output logic            bus_err_o
);
    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        RD_ADDR = 6'b000010,
        RD_DATA = 6'b000100,
        WR_ADDR = 6'b001000,
        WR_DATA = 6'b010000,
        WR_RESP = 6'b100000
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic        r_burst;
    logic        r_cached;
    logic [3:0]  r_strb;
    logic [3:0]  r_cnt;
    logic        r_err;
    logic [7:0]  w_len;
    logic [3:0]  w_cache;
    logic        w_beat;
    logic        w_clr;
    logic        w_err;
    logic        w_unused;

    assign w_len    = r_burst ? 8'(BURST_LEN - 1) : 8'd0;
    assign w_cache  = r_cached ? 4'b1111 : 4'b0000;
    // Upstream data_last is advisory only; the internal beat count decides wlast.
    assign w_unused = bus_req_i.data_last;

    assign arid      = AXI_ID;
    assign araddr    = r_addr;
    assign arlen     = w_len;
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;
    assign arcache   = w_cache;
    assign awid      = AXI_ID;
    assign awaddr    = r_addr;
    assign awlen     = w_len;
    assign awsize    = 3'b010;
    assign awburst   = 2'b01;
    assign awcache   = w_cache;
    assign wdata     = bus_req_i.w_data;
    assign wstrb     = r_strb;
    assign bus_err_o = r_err;

    always_comb begin
        w_next     = r_state;
        bus_resp_o = '0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        w_beat     = 1'b0;
        w_clr      = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus_req_i.valid) w_next = bus_req_i.write ? WR_ADDR : RD_ADDR;
            end
            RD_ADDR: begin
                arvalid          = 1'b1;
                bus_resp_o.ready = arready;
                w_clr            = arready;
                if (arready) w_next = RD_DATA;
            end
            RD_DATA: begin
                rready               = bus_req_i.data_ok;
                bus_resp_o.data_ok   = rvalid;
                bus_resp_o.r_data    = rdata;
                bus_resp_o.data_last = rlast;
                w_beat               = rvalid & bus_req_i.data_ok;
                // A short burst (rlast before the expected count) is flagged as an error.
                w_err = w_beat & ((rresp != 2'b00) | (rlast & (r_cnt != w_len[3:0])));
                if (w_beat && rlast) w_next = IDLE;
            end
            WR_ADDR: begin
                awvalid          = 1'b1;
                bus_resp_o.ready = awready;
                w_clr            = awready;
                if (awready) w_next = WR_DATA;
            end
            WR_DATA: begin
                wvalid               = bus_req_i.data_ok;
                wlast                = (r_cnt == w_len[3:0]);
                bus_resp_o.data_ok   = wready;
                bus_resp_o.data_last = wlast;
                w_beat               = bus_req_i.data_ok & wready;
                if (w_beat && wlast) w_next = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                w_err  = bvalid & (bresp != 2'b00);
                if (bvalid) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_burst  <= 1'b0;
            r_cached <= 1'b0;
            r_strb   <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus_req_i.valid) begin
                r_addr   <= bus_req_i.addr;
                r_burst  <= bus_req_i.burst;
                r_cached <= bus_req_i.cached;
                r_strb   <= bus_req_i.data_strobe;
            end
            if (w_clr) r_cnt <= '0;
            else if (w_beat) r_cnt <= r_cnt + 4'd1;
            if (w_err) r_err <= 1'b1;
        end
    end
endmodule
